// File: rtl/data_mem_pkg.sv
// ---------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the ping-pong frame memory (data_mem_pp):
//   - active-low / active-high strobe level constants
//   - frame-ownership state encoding
//   - frame counter width
// Optional feature macro used by the files that import this package:
//   DATA_MEM_PP_PARITY_EN (per-word even parity and rd_par_err output)
// ---------------------------------------------------------------------------
package data_mem_pkg;

    localparam logic ASSERT_L   = 1'b0;
    localparam logic DEASSERT_L = 1'b1;
    localparam logic ASSERT_H   = 1'b1;
    localparam logic DEASSERT_H = 1'b0;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        ACTIVE  = 2'd1,
        WR_HOLD = 2'd2,
        RD_HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/data_mem_pp_if.sv
// ---------------------------------------------------------------------------
// data_mem_pp_if
// Producer/consumer bus of the ping-pong frame memory.
//   Producer : wr_en(L), wr_addr, wr_data, wr_done(L) -> wr_rdy(H)
//   Consumer : rd_en(L), rd_addr, rd_done(L) -> rd_data, rd_valid(H)
//   Status   : wr_bank, rd_bank, frame_cnt
//   Optional : rd_par_err (present when DATA_MEM_PP_PARITY_EN is defined)
// Modports: slave (memory side), master (producer/consumer side).
// ---------------------------------------------------------------------------
interface data_mem_pp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) ();
    import data_mem_pkg::*;

    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   wr_done;
    logic                   wr_rdy;
    logic                   rd_en;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic                   rd_done;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_valid;
    logic                   wr_bank;
    logic                   rd_bank;
    logic [FRAME_CNT_W-1:0] frame_cnt;
`ifdef DATA_MEM_PP_PARITY_EN
    logic                   rd_par_err;
`endif

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        output wr_rdy, rd_data, rd_valid, wr_bank, rd_bank, frame_cnt
`ifdef DATA_MEM_PP_PARITY_EN
        , output rd_par_err
`endif
    );

    modport master (
        output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, rd_done,
        input  wr_rdy, rd_data, rd_valid, wr_bank, rd_bank, frame_cnt
`ifdef DATA_MEM_PP_PARITY_EN
        , input rd_par_err
`endif
    );

endinterface

// File: rtl/data_mem_bank.sv
// ---------------------------------------------------------------------------
// data_mem_bank
// One frame bank: a single write port, a single read port and an RD_LAT
// deep read pipeline. Strobes here are active-high; qualification (range,
// ownership, state) is done by the parent.
//   clk, reset (async, active-low)
//   wr_en, wr_addr, wr_data      : write port
//   rd_en, rd_addr               : read port
//   rd_data, rd_vld              : read result, rd_data holds between reads
//   rd_par_err                   : only with DATA_MEM_PP_PARITY_EN
// Contents are never cleared; only the read pipeline is reset.
// ---------------------------------------------------------------------------
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_vld
`ifdef DATA_MEM_PP_PARITY_EN
    ,
    output logic                  rd_par_err
`endif
);

`ifdef DATA_MEM_PP_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int WORD_W = DATA_WIDTH + PAR_W;
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [WORD_W-1:0] mem [MEM_DEPTH];
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] word_p0;
    logic [WORD_W-1:0] word_out;
    logic              vld_p0;

`ifdef DATA_MEM_PP_PARITY_EN
    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    assign wr_word = {even_parity(wr_data), wr_data};
`else
    assign wr_word = wr_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_word;
        end
    end

    // ---- stage p0: array read ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p0  <= DEASSERT_H;
            word_p0 <= '0;
        end else begin
            vld_p0 <= rd_en;
            if (rd_en) begin
                word_p0 <= mem[rd_addr[IDX_W-1:0]];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [WORD_W-1:0] word_p1;
            logic              vld_p1;

            // ---- stage p1: output register ----
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    vld_p1  <= DEASSERT_H;
                    word_p1 <= '0;
                end else begin
                    vld_p1 <= vld_p0;
                    if (vld_p0) begin
                        word_p1 <= word_p0;
                    end
                end
            end

            assign word_out = word_p1;
            assign rd_vld   = vld_p1;
        end else begin : g_lat1
            assign word_out = word_p0;
            assign rd_vld   = vld_p0;
        end
    endgenerate

    assign rd_data = word_out[DATA_WIDTH-1:0];

`ifdef DATA_MEM_PP_PARITY_EN
    // Stored parity makes the whole word even; any odd word is corrupted.
    assign rd_par_err = ^word_out;
`endif

endmodule

// File: rtl/data_mem_pp.sv
// ---------------------------------------------------------------------------
// data_mem_pp
// Ping-pong frame memory: the producer fills one bank while the consumer
// reads the previous frame from the other; banks swap on done handshakes.
//   clk    : clock, rising edge
//   reset  : asynchronous reset, active-low
//   bus    : data_mem_pp_if.slave (write/read ports, done pulses, status)
// Optional: DATA_MEM_PP_PARITY_EN adds per-word parity and bus.rd_par_err.
// ---------------------------------------------------------------------------
module data_mem_pp
    import data_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int MEM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int RD_LAT     = 1
) (
    input  logic         clk,
    input  logic         reset,
    data_mem_pp_if.slave bus
);

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    state_t                 state_q, state_d;
    logic                   swap;
    logic                   wr_bank_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic                   wr_done_q, rd_done_q;
    logic                   wr_ev, rd_ev;
    logic                   wr_rdy, wr_acc, rd_acc;
    logic                   b0_vld, b1_vld;
    logic [DATA_WIDTH-1:0]  b0_data, b1_data;
    logic                   rd_sel, rd_sel_q;

    // A done pulse is an event only on its first low cycle.
    assign wr_ev = (bus.wr_done == ASSERT_L) && (wr_done_q == DEASSERT_L);
    assign rd_ev = (bus.rd_done == ASSERT_L) && (rd_done_q == DEASSERT_L);

    assign wr_rdy = (state_q != WR_HOLD) ? ASSERT_H : DEASSERT_H;
    assign wr_acc = (bus.wr_en == ASSERT_L) && wr_rdy &&
                    ({1'b0, bus.wr_addr} < DEPTH_LIM);
    assign rd_acc = (bus.rd_en == ASSERT_L) && (state_q != EMPTY) &&
                    ({1'b0, bus.rd_addr} < DEPTH_LIM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (wr_ev) begin
                    swap    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (wr_ev && rd_ev) begin
                    swap = 1'b1;
                end else if (wr_ev) begin
                    state_d = WR_HOLD;
                end else if (rd_ev) begin
                    state_d = RD_HOLD;
                end
            end
            WR_HOLD: begin
                if (rd_ev) begin
                    swap    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            RD_HOLD: begin
                if (wr_ev) begin
                    swap    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q   <= 1'b0;
            frame_cnt_q <= '0;
            wr_done_q   <= DEASSERT_L;
            rd_done_q   <= DEASSERT_L;
            rd_sel_q    <= 1'b0;
        end else begin
            wr_done_q <= bus.wr_done;
            rd_done_q <= bus.rd_done;
            rd_sel_q  <= rd_sel;
            if (swap) begin
                wr_bank_q   <= ~wr_bank_q;
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

`ifdef DATA_MEM_PP_PARITY_EN
    logic b0_perr, b1_perr;
`endif

    // Each bank is written only while the writer owns it and read only
    // while the reader owns it; the bank is bound at accept time.
    data_mem_bank #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH(MEM_DEPTH),   .RD_LAT(RD_LAT)
    ) u_bank0 (
        .clk(clk), .reset(reset),
        .wr_en(wr_acc && !wr_bank_q), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
        .rd_en(rd_acc && wr_bank_q),  .rd_addr(bus.rd_addr),
        .rd_data(b0_data), .rd_vld(b0_vld)
`ifdef DATA_MEM_PP_PARITY_EN
        , .rd_par_err(b0_perr)
`endif
    );

    data_mem_bank #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH(MEM_DEPTH),   .RD_LAT(RD_LAT)
    ) u_bank1 (
        .clk(clk), .reset(reset),
        .wr_en(wr_acc && wr_bank_q),  .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
        .rd_en(rd_acc && !wr_bank_q), .rd_addr(bus.rd_addr),
        .rd_data(b1_data), .rd_vld(b1_vld)
`ifdef DATA_MEM_PP_PARITY_EN
        , .rd_par_err(b1_perr)
`endif
    );

    // Output follows the bank that produced the most recent result, so
    // rd_data holds across cycles without a valid read.
    assign rd_sel = b1_vld ? 1'b1 : (b0_vld ? 1'b0 : rd_sel_q);

    assign bus.rd_data   = rd_sel ? b1_data : b0_data;
    assign bus.rd_valid  = b0_vld | b1_vld;
    assign bus.wr_rdy    = wr_rdy;
    assign bus.wr_bank   = wr_bank_q;
    assign bus.rd_bank   = ~wr_bank_q;
    assign bus.frame_cnt = frame_cnt_q;

`ifdef DATA_MEM_PP_PARITY_EN
    assign bus.rd_par_err = (b0_vld | b1_vld) & (rd_sel ? b1_perr : b0_perr);
`endif

endmodule
